// File: rtl/quad_pkg.sv
// Shared phase/direction definitions and transition classification for the quadrature decoder.
// Phases are encoded {A,B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
package quad_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_UP   = 2'd1,
    TR_DN   = 2'd2,
    TR_ILL  = 2'd3
  } trans_t;

  function automatic phase_t next_up(input phase_t ph);
    phase_t nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  // A down step is an up step seen backwards; anything two phases away is illegal.
  function automatic trans_t classify(input phase_t old_ph, input phase_t new_ph);
    trans_t tr;
    if (new_ph == old_ph) begin
      tr = TR_NONE;
    end else if (new_ph == next_up(old_ph)) begin
      tr = TR_UP;
    end else if (old_ph == next_up(new_ph)) begin
      tr = TR_DN;
    end else begin
      tr = TR_ILL;
    end
    return tr;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchronises A/B and accepts a new phase once it has been stable for FILT_CYCLES samples.
// f_ab/f_valid update FILT_CYCLES+1 edges after the first edge that samples a new level.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int FILT_CYCLES = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   a_i,
  input  logic   b_i,
  output phase_t f_ab_o,
  output logic   f_valid_o
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYCLES);

  phase_t        sync1_q, sync2_q;
  phase_t        last_q;
  logic [CW-1:0] cnt_q, cnt_d;
  phase_t        f_ab_q, f_ab_d;
  logic          f_valid_q, f_valid_d;
  logic          primed_q, primed_d;

  phase_t        s_ab;
  logic          want;
  logic [CW-1:0] run;

  assign s_ab = sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= PH_00;
      sync2_q   <= PH_00;
      last_q    <= PH_00;
      cnt_q     <= '0;
      f_ab_q    <= PH_00;
      f_valid_q <= 1'b0;
      primed_q  <= 1'b0;
    end else begin
      sync1_q   <= {a_i, b_i};
      sync2_q   <= sync1_q;
      last_q    <= s_ab;
      cnt_q     <= cnt_d;
      f_ab_q    <= f_ab_d;
      f_valid_q <= f_valid_d;
      primed_q  <= primed_d;
    end
  end

  // Until the first phase is accepted, even the reset phase must prove itself stable,
  // so the decoder always gets one silent adoption strobe after reset.
  always_comb begin
    want      = !primed_q || (s_ab != f_ab_q);
    run       = (s_ab == last_q) ? cnt_q + CW'(1) : CW'(1);
    cnt_d     = '0;
    f_ab_d    = f_ab_q;
    f_valid_d = 1'b0;
    primed_d  = primed_q;
    if (want) begin
      if (run == FILT_MAX) begin
        f_ab_d    = s_ab;
        f_valid_d = 1'b1;
        primed_d  = 1'b1;
      end else begin
        cnt_d = run;
      end
    end
  end

  assign f_ab_o    = f_ab_q;
  assign f_valid_o = f_valid_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B phases drive Step/UpOrDown/Count plus illegal-jump error reporting.
// Outputs update FILT_CYCLES+2 edges after the first edge that samples a new input level.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int FILT_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 A,
  input  logic                 B,
  input  logic                 Load,
  input  logic [CNT_WIDTH-1:0] LoadVal,
  input  logic                 ClrErr,
  output logic                 Step,
  output logic                 UpOrDown,
  output logic [CNT_WIDTH-1:0] Count,
  output logic                 Error,
  output logic                 ErrFlag
);

  phase_t f_ab;
  logic   f_valid;

  quad_input_filter #(
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filter (
    .clk_i    (Clk),
    .rst_i    (reset),
    .a_i      (A),
    .b_i      (B),
    .f_ab_o   (f_ab),
    .f_valid_o(f_valid)
  );

  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 error_q, error_d;
  logic                 err_flag_q, err_flag_d;
  logic                 init_q, init_d;
  phase_t               phase_q, phase_d;
  trans_t               trans;

  always_ff @(posedge Clk) begin
    if (reset) begin
      step_q     <= 1'b0;
      dir_q      <= DIR_UP;
      count_q    <= '0;
      error_q    <= 1'b0;
      err_flag_q <= 1'b0;
      init_q     <= 1'b1;
      phase_q    <= PH_00;
    end else begin
      step_q     <= step_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      error_q    <= error_d;
      err_flag_q <= err_flag_d;
      init_q     <= init_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    trans      = (f_valid && !init_q) ? classify(phase_q, f_ab) : TR_NONE;
    step_d     = 1'b0;
    error_d    = 1'b0;
    dir_d      = dir_q;
    count_d    = count_q;
    err_flag_d = err_flag_q;
    init_d     = init_q;
    phase_d    = phase_q;

    // The tracked phase follows every accepted update, illegal ones included,
    // so decoding resumes from wherever the encoder really is.
    if (f_valid) begin
      phase_d = f_ab;
      init_d  = 1'b0;
    end

    case (trans)
      TR_UP: begin
        step_d  = 1'b1;
        dir_d   = DIR_UP;
        count_d = count_q + CNT_WIDTH'(1);
      end
      TR_DN: begin
        step_d  = 1'b1;
        dir_d   = DIR_DN;
        count_d = count_q - CNT_WIDTH'(1);
      end
      TR_ILL:  error_d = 1'b1;
      default: ;
    endcase

    if (Load) begin
      count_d = LoadVal;
    end

    if (trans == TR_ILL) begin
      err_flag_d = 1'b1;
    end else if (ClrErr) begin
      err_flag_d = 1'b0;
    end
  end

  assign Step     = step_q;
  assign UpOrDown = dir_q;
  assign Count    = count_q;
  assign Error    = error_q;
  assign ErrFlag  = err_flag_q;

endmodule
